// File: rtl/bf_pkg.sv
// Shared definitions for the Blowfish plaintext front end: block geometry,
// packer state encoding and the PKCS#7 full pad block.
package bf_pkg;

    localparam int BF_BLOCK_W = 64;
    localparam int BF_BYTE_W  = 8;
    localparam int BF_BYTES   = 8;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        PADBLK = 1'b1
    } bf_state_e;

    localparam logic [BF_BLOCK_W-1:0] BF_PAD_FULL = 64'h0808080808080808;

endpackage

// File: rtl/bf_pkcs7_fill.sv
// Completes a partially assembled block: lanes at or beyond byte count n
// receive the PKCS#7 pad value (8-n), or zero when padding is disabled.
module bf_pkcs7_fill
    import bf_pkg::*;
(
    input  logic [BF_BLOCK_W-1:0] partial,
    input  logic [3:0]            n,
    input  logic                  pad_en,
    output logic [BF_BLOCK_W-1:0] block
);

    logic [BF_BYTE_W-1:0] pad_byte_s;

    // Pad value and per-lane selection between accepted data and padding
    always_comb begin
        block      = partial;
        pad_byte_s = pad_en ? (8'd8 - {4'd0, n}) : 8'h00;
        for (int k = 0; k < BF_BYTES; k++) begin
            if (4'(k) >= n) begin
                block[BF_BLOCK_W-1-BF_BYTE_W*k -: BF_BYTE_W] = pad_byte_s;
            end else begin
                block[BF_BLOCK_W-1-BF_BYTE_W*k -: BF_BYTE_W] =
                    partial[BF_BLOCK_W-1-BF_BYTE_W*k -: BF_BYTE_W];
            end
        end
    end

endmodule

// File: rtl/bf_block_packer.sv
// Packs a byte stream big-endian into 64-bit blocks with optional PKCS#7
// padding and presents them on a registered valid/ready output.
module bf_block_packer
    import bf_pkg::*;
#(
    parameter bit PAD_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BF_BYTE_W-1:0]  s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [BF_BLOCK_W-1:0] m_block,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);

    bf_state_e             state_r, state_nxt_s;
    logic [2:0]            cnt_r, cnt_nxt_s;
    logic [BF_BLOCK_W-1:0] asm_r, asm_nxt_s;
    logic [BF_BLOCK_W-1:0] m_block_r;
    logic                  m_valid_r, m_last_r;

    logic                  out_free_s, accept_s;
    logic [BF_BLOCK_W-1:0] partial_s, filled_s, load_blk_s;
    logic [3:0]            fill_n_s;
    logic                  load_s, load_last_s;

    assign out_free_s = !m_valid_r || m_ready;
    assign s_ready    = (state_r == FILL) && out_free_s;
    assign accept_s   = s_valid && s_ready;
    assign fill_n_s   = {1'b0, cnt_r} + 4'd1;

    assign m_block = m_block_r;
    assign m_valid = m_valid_r;
    assign m_last  = m_last_r;

    // Assembly register with the incoming byte merged into lane cnt
    always_comb begin
        partial_s = asm_r;
        for (int k = 0; k < BF_BYTES; k++) begin
            if (3'(k) == cnt_r) begin
                partial_s[BF_BLOCK_W-1-BF_BYTE_W*k -: BF_BYTE_W] = s_data;
            end else begin
                partial_s[BF_BLOCK_W-1-BF_BYTE_W*k -: BF_BYTE_W] =
                    asm_r[BF_BLOCK_W-1-BF_BYTE_W*k -: BF_BYTE_W];
            end
        end
    end

    bf_pkcs7_fill u_fill (
        .partial (partial_s),
        .n       (fill_n_s),
        .pad_en  (PAD_EN),
        .block   (filled_s)
    );

    // Next-state, fill bookkeeping and output-load decisions
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        asm_nxt_s   = asm_r;
        load_s      = 1'b0;
        load_blk_s  = filled_s;
        load_last_s = 1'b0;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    if (s_last || (cnt_r == 3'd7)) begin
                        load_s    = 1'b1;
                        cnt_nxt_s = 3'd0;
                        asm_nxt_s = '0;
                        // A full final block still owes a whole pad block
                        if (s_last && (cnt_r == 3'd7) && PAD_EN) begin
                            load_last_s = 1'b0;
                            state_nxt_s = PADBLK;
                        end else begin
                            load_last_s = s_last;
                            state_nxt_s = FILL;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + 3'd1;
                        asm_nxt_s = partial_s;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                    asm_nxt_s = asm_r;
                end
            end
            PADBLK: begin
                if (out_free_s) begin
                    load_s      = 1'b1;
                    load_blk_s  = BF_PAD_FULL;
                    load_last_s = 1'b1;
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = PADBLK;
                end
            end
            default: begin
                state_nxt_s = FILL;
            end
        endcase
    end

    // State, fill count and assembly register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FILL;
            cnt_r   <= 3'd0;
            asm_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            asm_r   <= asm_nxt_s;
        end
    end

    // Output register: load wins over consume so back-to-back blocks stream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_block_r <= '0;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else if (load_s) begin
            m_block_r <= load_blk_s;
            m_valid_r <= 1'b1;
            m_last_r  <= load_last_s;
        end else if (m_ready) begin
            m_valid_r <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
        end
    end

endmodule

// File: tb/tb_bf_block_packer.sv
// Scoreboard bench for bf_block_packer: directed vectors on a padding and a
// non-padding instance, then random-length messages against a PKCS#7 model.
module tb_bf_block_packer;

    typedef struct packed {
        logic [63:0] blk;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data, s_data0;
    logic        s_valid, s_valid0, s_last, s_last0;
    logic        s_ready, s_ready0;
    logic [63:0] m_block, m_block0;
    logic        m_valid, m_valid0, m_last, m_last0;
    logic        m_ready, m_ready0;

    exp_t        sb_q[$];
    exp_t        sb0_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          valid_cycles = 0;
    int          sready_low = 0;
    int          last_seen = 0;
    logic [63:0] mdl_buf;
    int          mdl_n;
    bit          rnd_done;

    always #5 clk = ~clk;

    bf_block_packer #(.PAD_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready), .m_block(m_block),
        .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
    );

    bf_block_packer #(.PAD_EN(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data0), .s_valid(s_valid0),
        .s_last(s_last0), .s_ready(s_ready0), .m_block(m_block0),
        .m_valid(m_valid0), .m_last(m_last0), .m_ready(m_ready0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic push(input logic [63:0] b, input logic l);
        exp_t e;
        e.blk = b; e.last = l;
        sb_q.push_back(e);
    endtask

    task automatic push0(input logic [63:0] b, input logic l);
        exp_t e;
        e.blk = b; e.last = l;
        sb0_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one byte and returns at posedge+1 after it is accepted
    task automatic send(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        s_data = d; s_valid = 1'b1; s_last = l;
        forever begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk); #1;
                break;
            end
            t++;
            if (t > 200) begin
                n_checks++;
                $display("FAIL send_timeout: s_ready stuck at 0, expected 1");
                break;
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send0(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        s_data0 = d; s_valid0 = 1'b1; s_last0 = l;
        forever begin
            @(negedge clk);
            if (s_ready0) begin
                @(posedge clk); #1;
                break;
            end
            t++;
            if (t > 200) begin
                n_checks++;
                $display("FAIL send0_timeout: s_ready stuck at 0, expected 1");
                break;
            end
        end
        s_valid0 = 1'b0; s_last0 = 1'b0;
    endtask

    // Reference PKCS#7 packer used for the random messages
    task automatic model_push(input logic [7:0] d, input logic l);
        mdl_buf[63-8*mdl_n -: 8] = d;
        mdl_n++;
        if (l) begin
            if (mdl_n < 8) begin
                for (int k = mdl_n; k < 8; k++) mdl_buf[63-8*k -: 8] = 8'(8 - mdl_n);
                push(mdl_buf, 1'b1);
            end else begin
                push(mdl_buf, 1'b0);
                push(64'h0808080808080808, 1'b1);
            end
            mdl_n = 0; mdl_buf = 64'd0;
        end else if (mdl_n == 8) begin
            push(mdl_buf, 1'b0);
            mdl_n = 0; mdl_buf = 64'd0;
        end
    endtask

    // Monitor for the padding instance
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_block: got %h, expected no block", m_block);
            end else begin
                e = sb_q.pop_front();
                check("m_block", m_block, e.blk);
                check("m_last", {63'd0, m_last}, {63'd0, e.last});
            end
            if (m_last) last_seen++;
        end
        valid_cycles += int'(m_valid);
        if (!s_ready) sready_low++;
    end

    // Monitor for the zero-fill instance
    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst_n && m_valid0 && m_ready0) begin
            if (sb0_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_block0: got %h, expected no block", m_block0);
            end else begin
                e = sb0_q.pop_front();
                check("m_block0", m_block0, e.blk);
                check("m_last0", {63'd0, m_last0}, {63'd0, e.last});
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        s_data = 8'd0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        s_data0 = 8'd0; s_valid0 = 1'b0; s_last0 = 1'b0; m_ready0 = 1'b1;
        cycles(2);
        check("reset_m_valid", {63'd0, m_valid}, 64'd0);
        check("reset_m_block", m_block, 64'd0);
        check("reset_m_last", {63'd0, m_last}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_s_ready", {63'd0, s_ready}, 64'd1);
        @(posedge clk); #1;

        // Five-byte message
        valid_cycles = 0; sready_low = 0;
        push(64'h0102030405030303, 1'b1);
        for (int i = 1; i <= 5; i++) send(8'(i), i == 5);
        cycles(3);
        check("t1_valid_cycles", 64'(valid_cycles), 64'd1);
        check("t1_sready_low", 64'(sready_low), 64'd0);

        // Full eight-byte message followed by the pad block
        valid_cycles = 0; sready_low = 0;
        push(64'h0102030405060708, 1'b0);
        push(64'h0808080808080808, 1'b1);
        for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
        cycles(3);
        check("t2_valid_cycles", 64'(valid_cycles), 64'd2);
        check("t2_sready_low", 64'(sready_low), 64'd1);

        // Single byte
        push(64'hAA07070707070707, 1'b1);
        send(8'hAA, 1'b1);
        cycles(2);

        // Back-pressure hold across a block boundary
        m_ready = 1'b0;
        push(64'h0001020304050607, 1'b0);
        push(64'h08090A0B0C0D0E0F, 1'b0);
        for (int i = 0; i < 8; i++) send(8'(i), 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_block", m_block, 64'h0001020304050607);
            check("hold_s_ready", {63'd0, s_ready}, 64'd0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        for (int i = 8; i < 16; i++) send(8'(i), 1'b0);
        cycles(3);
        check("hold_queue_empty", 64'(sb_q.size()), 64'd0);

        // Reset with a held block, then with a partial block
        m_ready = 1'b0;
        push(64'h2122232425262728, 1'b0);
        for (int i = 0; i < 8; i++) send(8'(8'h21 + i), 1'b0);
        #2 rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("rst_held_m_valid", {63'd0, m_valid}, 64'd0);
        check("rst_held_m_block", m_block, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(8'(8'h31 + i), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_part_m_valid", {63'd0, m_valid}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(64'h1112131415161718, 1'b0);
        push(64'h0808080808080808, 1'b1);
        for (int i = 0; i < 8; i++) send(8'(8'h11 + i), i == 7);
        cycles(3);
        check("rst_queue_empty", 64'(sb_q.size()), 64'd0);

        // Zero-fill instance
        push0(64'hAA00000000000000, 1'b1);
        send0(8'hAA, 1'b1);
        push0(64'h0102030405060708, 1'b1);
        for (int i = 1; i <= 8; i++) send0(8'(i), i == 8);
        cycles(3);
        check("nopad_queue_empty", 64'(sb0_q.size()), 64'd0);

        // Random messages with random gaps and back-pressure
        last_seen = 0; mdl_n = 0; mdl_buf = 64'd0; rnd_done = 1'b0;
        fork
            begin
                for (int m = 0; m < 1000; m++) begin
                    int len;
                    len = $urandom_range(1, 20);
                    for (int b = 0; b < len; b++) begin
                        logic [7:0] d;
                        d = 8'($urandom_range(0, 255));
                        if ($urandom_range(0, 3) == 0) cycles(1);
                        model_push(d, b == len - 1);
                        send(d, b == len - 1);
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    m_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_ready = 1'b1;
        for (int c = 0; c < 200 && sb_q.size() != 0; c++) cycles(1);
        cycles(2);
        check("rnd_queue_empty", 64'(sb_q.size()), 64'd0);
        check("rnd_last_count", 64'(last_seen), 64'd1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bf_block_packer.md
Name: bf_block_packer

Overview:
- Upstream feeder for the Blowfish encryption datapath.
- Accepts a byte-serial plaintext message on a valid/ready stream and packs it big-endian into 64-bit blocks.
- Applies PKCS#7 padding to the final block and presents each block on a registered valid/ready output that drives the 64-bit Blowfish plaintext input.
- Marks the final block of each message.

Parameters:
- PAD_EN, 1, 1 = PKCS#7 padding enabled; 0 = no padding: a partial final block is zero-filled and no extra pad block is generated.

Ports:
- clk  input  1  single clock
- rst_n  input  1  reset, active-low
- s_data  input  8  plaintext byte
- s_valid  input  1  s_data valid
- s_last  input  1  final byte of message, qualified by s_valid
- s_ready  output  1  byte accepted when s_valid && s_ready at rising clk
- m_block  output  64  packed plaintext block to Blowfish datapath
- m_valid  output  1  m_block valid
- m_last  output  1  m_block is final block of message
- m_ready  input  1  block consumed when m_valid && m_ready at rising clk

Interface rules:
- One clock; reset is asynchronous and active-low.
- All outputs are registered except s_ready.

Behaviour:
- Reset values:
  - m_block = 0, m_valid = 0, m_last = 0
  - fill count cnt = 0, assembly register = 0
  - state = FILL; s_ready = 1 after reset release.
- Byte order: first accepted byte of a block occupies bits [63:56]; byte k occupies [63-8k -: 8].
- s_ready = (state == FILL) && (!m_valid || m_ready).
  - Conservative: it never depends on s_valid or s_last.
- Accept in FILL, not last:
  - Byte written to lane cnt; cnt increments.
  - At cnt == 7, the completed block loads m_block with m_valid = 1 and m_last = 0 on the same edge; cnt wraps to 0.
- Accept in FILL with s_last at cnt = c (n = c+1 bytes in block):
  - n < 8: lanes n..7 are filled with byte value 8-n (PAD_EN = 1) or 0x00 (PAD_EN = 0). m_block loads with m_valid = 1, m_last = 1; cnt = 0; state stays FILL.
  - n == 8, PAD_EN = 1: block loads with m_last = 0; state goes to PADBLK.
  - n == 8, PAD_EN = 0: block loads with m_last = 1; state stays FILL.
- PADBLK:
  - s_ready = 0.
  - When the output is free or draining (!m_valid || m_ready), m_block loads 0x0808080808080808 with m_valid = 1, m_last = 1; state returns to FILL.
- Output handshake:
  - m_block and m_last are held stable while m_valid && !m_ready.
  - m_valid clears on consume unless a new block loads on the same edge. Back-to-back load and consume on one edge is legal.
- Latency and throughput:
  - Block appears on m_* the cycle after its completing byte is accepted.
  - Sustained throughput is 1 byte/cycle when m_ready = 1.
- Bytes with s_valid low are ignored; cnt holds.
- A message of zero bytes cannot be expressed; s_last always accompanies a real byte.
- Reset mid-operation: partial block, pending PADBLK and held output are discarded. The first byte after reset goes to lane 0.

Decomposition:
- Shared package bf_pkg: BF_BLOCK_W = 64, BF_BYTE_W = 8, BF_BYTES = 8, state enum {FILL, PADBLK}, PKCS#7 full-pad constant 64'h0808080808080808.
- One natural combinational sub-module, bf_pkcs7_fill:
  - Inputs: partial block, byte count n, PAD_EN.
  - Output: padded 64-bit block.
  - Instantiated once in the load path.

Test Plan:
- Bytes 01 02 03 04 05 (last on 05), m_ready = 1 -> one block 0x0102030405030303, m_last = 1, m_valid for exactly one cycle; s_ready never drops.
- Bytes 01..08 (last on 08), PAD_EN = 1 -> 0x0102030405060708 with m_last = 0, then 0x0808080808080808 with m_last = 1 on the next cycle; s_ready low for exactly one cycle during PADBLK.
- Single byte AA with last -> 0xAA07070707070707, m_last = 1. Repeat with PAD_EN = 0 -> 0xAA00000000000000, m_last = 1.
- 16 bytes 00..0F, no last, m_ready held low 5 cycles after first block -> 0x0001020304050607 held stable for 5 cycles; s_ready = 0 while held. After release, 0x08090A0B0C0D0E0F follows with no byte lost or duplicated.
- Three bytes accepted, then rst_n pulsed low mid-cycle -> m_valid = 0 immediately. A subsequent 8-byte message 11..18 with last -> 0x1112131415161718 then the full pad block; no residue from pre-reset bytes.
- Random s_valid/m_ready toggling over 1000 random-length messages against a software PKCS#7 model -> exact block stream match and m_last exactly once per message.
